fifo_arb_ctrl: RTL and testbench

Controller that shares one 4-entry FIFO (`statelogic`-sequenced, `wp`/`rp` pointer FIFO) between two producers and drains it into a registered ready/valid output stage. It round-robin arbitrates the single write port, gates pops on downstream backpressure, and mirrors FIFO occupancy to flag protocol errors. It also supports a flush sequence that discards the FIFO contents. The block sits between the producer interfaces and the FIFO datapath: it drives `data_in_valid`/`pop_fifo` and consumes `fifo_full`/`fifo_empty`.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_arb_ctrl_if.sv | 49 ++++
 rtl/fifo_arb_ctrl_rr_arb2.sv | 46 ++++
 rtl/fifo_arb_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_arb_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO arbitration controller.
//   state_t      : controller FSM states (RUN / FLUSH / DONE)
//   WIDTH_DEF    : default data width
//   DEPTH_DEF    : default FIFO depth
//   count_width(): width of an occupancy counter that can hold 0..depth
package fifo_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_arb_ctrl_if.sv
// Bundle of every handshake/bus signal around fifo_arb_ctrl.
//   producers  : req0/req1, data0/data1 in; gnt0/gnt1 out
//   FIFO write : fifo_data_in, data_in_valid out
//   FIFO read  : fifo_full, fifo_empty, fifo_data_out in; pop_fifo out
//   output     : out_valid, out_data out; out_ready in
//   control    : flush in; flush_done, count, err out
// master = the controller, slave = its environment (producers, FIFO, sink).
interface fifo_arb_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    logic                          req0;
    logic                          req1;
    logic [WIDTH-1:0]              data0;
    logic [WIDTH-1:0]              data1;
    logic                          gnt0;
    logic                          gnt1;
    logic [WIDTH-1:0]              fifo_data_in;
    logic                          data_in_valid;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [WIDTH-1:0]              fifo_data_out;
    logic                          pop_fifo;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_data;
    logic                          out_ready;
    logic                          flush;
    logic                          flush_done;
    logic [count_width(DEPTH)-1:0] count;
    logic                          err;

    modport master (
        input  req0, req1, data0, data1, fifo_full, fifo_empty, fifo_data_out,
               out_ready, flush,
        output gnt0, gnt1, fifo_data_in, data_in_valid, pop_fifo, out_valid,
               out_data, flush_done, count, err
    );

    modport slave (
        output req0, req1, data0, data1, fifo_full, fifo_empty, fifo_data_out,
               out_ready, flush,
        input  gnt0, gnt1, fifo_data_in, data_in_valid, pop_fifo, out_valid,
               out_data, flush_done, count, err
    );

endinterface

// File: rtl/fifo_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grants allowed this cycle
//   req0, req1 : requests
//   gnt0, gnt1 : combinational one-hot grants
// `last` remembers the most recent winner; on a tie the other requester wins.
// It resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last;

    always_comb begin
        // NOTE: defaults first so every path assigns both grants; no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end else if (gnt1) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: shares one FIFO between two producers and drains it into a
// registered ready/valid output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_arb_ctrl_if.master -- producer grants, FIFO push/pop,
//                output register, flush handshake, occupancy mirror, error flag
// The FSM (RUN/FLUSH/DONE), output register, count mirror and error checker
// live here; write arbitration is delegated to rr_arb2.
module fifo_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_arb_ctrl_if.master bus
);

    localparam int            CW       = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic             grant_en;
    logic             push;
    logic             pop;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    count_q;
    logic             err_q;
    logic             err_now;

    // Gating with rst_n keeps every combinational output low while reset is held.
    assign run      = (state == RUN) && rst_n;
    assign grant_en = run && !bus.fifo_full;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (grant_en),
        .req0 (bus.req0),
        .req1 (bus.req1),
        .gnt0 (bus.gnt0),
        .gnt1 (bus.gnt1)
    );

    assign push              = bus.gnt0 | bus.gnt1;
    assign bus.data_in_valid = push;
    assign bus.fifo_data_in  = bus.gnt1 ? bus.data1 : bus.data0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush is only sampled in RUN; FLUSH drains regardless of out_ready.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            RUN: begin
                pop = !bus.fifo_empty && (!out_valid_q || bus.out_ready);
                if (bus.flush) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                pop = !bus.fifo_empty;
                if (bus.fifo_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (!rst_n) begin
            pop = 1'b0;
        end
    end

    assign bus.pop_fifo   = pop;
    assign bus.flush_done = (state == DONE);

    // A flush request kills the output word immediately; words popped while
    // flushing are dropped on the floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (state == RUN && !bus.flush) begin
            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.fifo_data_out;
            end else if (bus.out_ready && out_valid_q) begin
                out_valid_q <= 1'b0;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Occupancy mirror: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   if (count_q != FULL_CNT) count_q <= count_q + CW'(1);
                2'b01:   if (count_q != '0)       count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.count = count_q;

    // Any disagreement between the mirror and the FIFO's own status, or an
    // access the mirror says is impossible, latches the error until reset.
    assign err_now = (push && count_q == FULL_CNT)
                   || (pop && count_q == '0)
                   || (bus.fifo_empty != (count_q == '0))
                   || (bus.fifo_full  != (count_q == FULL_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Self-checking bench for fifo_arb_ctrl: an ideal queue-based FIFO sits on the
// FIFO side, and a behavioural model of the controller predicts every output
// each cycle. Directed scenarios pin the model with literal expectations, and
// a randomized phase exercises arbitration, backpressure and flush mixes.
module tb_fifo_arb_ctrl;
    import fifo_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_arb_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Ideal FIFO contents and an override that lies about emptiness.
    logic [WIDTH-1:0] fq[$];
    bit               inj_empty;

    // Behavioural model state.
    bit               m_flushing;
    bit               m_done;
    bit               m_last;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    int               m_cnt;
    bit               m_err;

    // DUT values seen at the most recent compare point.
    logic             s_gnt0, s_gnt1, s_pop, s_ov, s_fd, s_full, s_err;
    logic [WIDTH-1:0] s_od;
    int               s_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_drive();
        bus.fifo_full     = (fq.size() == DEPTH);
        bus.fifo_empty    = inj_empty || (fq.size() == 0);
        bus.fifo_data_out = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic model_reset();
        m_flushing = 0;
        m_done     = 0;
        m_last     = 1;
        m_ov       = 0;
        m_od       = '0;
        m_cnt      = 0;
        m_err      = 0;
    endtask

    // One clock: compare at the falling edge, then advance model and FIFO just
    // after the rising edge. Called (and returns) at posedge + 1.
    task automatic step();
        bit               run, e_g0, e_g1, e_pop, full, empty, fl, rdy, d_push, d_pop;
        logic [WIDTH-1:0] head, wdata;
        @(negedge clk);
        full  = bus.fifo_full;
        empty = bus.fifo_empty;
        head  = bus.fifo_data_out;
        fl    = bus.flush;
        rdy   = bus.out_ready;
        run   = !m_flushing && !m_done;
        e_g0  = 0;
        e_g1  = 0;
        if (run && !full) begin
            if (bus.req0 && bus.req1) begin
                if (m_last) e_g0 = 1; else e_g1 = 1;
            end else begin
                e_g0 = bus.req0;
                e_g1 = bus.req1;
            end
        end
        if (run)             e_pop = !empty && (!m_ov || rdy);
        else if (m_flushing) e_pop = !empty;
        else                 e_pop = 0;

        check("gnt0", 32'(bus.gnt0), 32'(e_g0));
        check("gnt1", 32'(bus.gnt1), 32'(e_g1));
        check("data_in_valid", 32'(bus.data_in_valid), 32'(e_g0 | e_g1));
        if (e_g0 | e_g1)
            check("fifo_data_in", 32'(bus.fifo_data_in), 32'(e_g1 ? bus.data1 : bus.data0));
        check("pop_fifo", 32'(bus.pop_fifo), 32'(e_pop));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(bus.out_data), 32'(m_od));
        check("count", 32'(bus.count), 32'(m_cnt));
        check("err", 32'(bus.err), 32'(m_err));
        check("flush_done", 32'(bus.flush_done), 32'(m_done));

        s_gnt0 = bus.gnt0;  s_gnt1 = bus.gnt1;  s_pop = bus.pop_fifo;
        s_ov   = bus.out_valid; s_od = bus.out_data; s_fd = bus.flush_done;
        s_full = bus.fifo_full; s_err = bus.err; s_cnt = int'(bus.count);
        d_push = bus.data_in_valid;
        d_pop  = bus.pop_fifo;
        wdata  = bus.fifo_data_in;

        @(posedge clk);
        #1;
        if (((e_g0 | e_g1) && m_cnt == DEPTH) || (e_pop && m_cnt == 0) ||
            (empty != (m_cnt == 0)) || (full != (m_cnt == DEPTH)))
            m_err = 1;
        if ((e_g0 | e_g1) && !e_pop && m_cnt < DEPTH) m_cnt++;
        if (e_pop && !(e_g0 | e_g1) && m_cnt > 0)    m_cnt--;
        if (e_g0)      m_last = 0;
        else if (e_g1) m_last = 1;
        if (run) begin
            if (fl) begin
                m_flushing = 1;
                m_ov       = 0;
            end else if (e_pop) begin
                m_ov = 1;
                m_od = head;
            end else if (rdy) begin
                m_ov = 0;
            end
        end else if (m_flushing) begin
            m_ov = 0;
            if (empty) begin
                m_flushing = 0;
                m_done     = 1;
            end
        end else begin
            m_done = 0;
        end
        // The FIFO reacts to what the DUT actually asked for.
        if (d_pop && fq.size() > 0)      void'(fq.pop_front());
        if (d_push && fq.size() < DEPTH) fq.push_back(wdata);
        fifo_drive();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
        bus.out_ready = 0; bus.flush = 0;
        inj_empty = 0;
        fq.delete();
        fifo_drive();
        model_reset();

        // Reset values.
        rst_n = 0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_flush_done", 32'(bus.flush_done), 0);
        check("rst_pop", 32'(bus.pop_fifo), 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Single write flows through with two-cycle latency.
        bus.req0 = 1; bus.data0 = 16'hA001; bus.out_ready = 1;
        step();
        check("t1_gnt0", 32'(s_gnt0), 1);
        bus.req0 = 0;
        step();
        check("t1_pop", 32'(s_pop), 1);
        step();
        check("t1_out_valid", 32'(s_ov), 1);
        check("t1_out_data", 32'(s_od), 32'h0000_A001);
        check("t1_count", 32'(s_cnt), 0);
        step();

        // Park one word in the output register (req1 wins, so req0 wins next tie).
        bus.out_ready = 0;
        bus.req1 = 1; bus.data1 = 16'hB000;
        step();
        bus.req1 = 0;
        step();
        step();

        // Both requesting: alternating grants until the FIFO fills.
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = 16'hC000 + 16'(i);
            bus.data1 = 16'hD000 + 16'(i);
            step();
            check("t2_gnt0_alt", 32'(s_gnt0), 32'(i % 2 == 0));
            check("t2_gnt1_alt", 32'(s_gnt1), 32'(i % 2 == 1));
        end
        step();
        check("t2_full", 32'(s_full), 1);
        check("t2_count", 32'(s_cnt), 4);
        check("t2_gnt0_blocked", 32'(s_gnt0), 0);
        check("t2_gnt1_blocked", 32'(s_gnt1), 0);

        // Full with a pop: the write waits one cycle.
        bus.req0 = 0; bus.req1 = 1; bus.data1 = 16'hD0D0; bus.out_ready = 1;
        step();
        check("t3_pop", 32'(s_pop), 1);
        check("t3_gnt1_full", 32'(s_gnt1), 0);
        step();
        check("t3_gnt1_next", 32'(s_gnt1), 1);
        bus.req1 = 0;
        repeat (8) step();
        step();
        check("t3_drained_cnt", 32'(s_cnt), 0);
        check("t3_drained_ov", 32'(s_ov), 0);

        // Three buffered words plus one held in the output register, then flush.
        bus.out_ready = 0; bus.req0 = 1;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = 16'hE000 + 16'(i);
            step();
        end
        bus.req0 = 0; bus.flush = 1;
        step();
        bus.flush = 0; bus.req1 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_flush_pop", 32'(s_pop), 32'(i < 3));
            check("t4_flush_ov", 32'(s_ov), 0);
            check("t4_flush_done", 32'(s_fd), 32'(i == 4));
            check("t4_flush_gnt1", 32'(s_gnt1), 0);
        end
        bus.req1 = 0; bus.req0 = 1; bus.data0 = 16'h5A5A;
        step();
        check("t4_after_gnt0", 32'(s_gnt0), 1);
        check("t4_after_done", 32'(s_fd), 0);
        check("t4_after_count", 32'(s_cnt), 0);
        bus.req0 = 0; bus.out_ready = 1;
        repeat (4) step();

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 600; n++) begin
            bus.req0      = 1'($urandom % 2);
            bus.req1      = 1'($urandom % 2);
            bus.data0     = 16'($urandom);
            bus.data1     = 16'($urandom);
            bus.out_ready = ($urandom % 4) != 0;
            bus.flush     = ($urandom % 24) == 0;
            step();
        end
        bus.req0 = 0; bus.req1 = 0; bus.flush = 0; bus.out_ready = 1;
        repeat (12) step();

        // Two words in the FIFO, then the FIFO lies about being empty.
        bus.out_ready = 0; bus.req0 = 1;
        for (int i = 0; i < 3; i++) begin
            bus.data0 = 16'h7000 + 16'(i);
            step();
        end
        bus.req0 = 0;
        step();
        check("t5_count", 32'(s_cnt), 2);
        check("t5_err_clean", 32'(s_err), 0);
        inj_empty = 1;
        fifo_drive();
        step();
        inj_empty = 0;
        fifo_drive();
        step();
        check("t5_err_set", 32'(s_err), 1);
        repeat (3) step();
        check("t5_err_sticky", 32'(s_err), 1);

        // Reset in the middle of a flush.
        bus.flush = 1;
        step();
        bus.flush = 0;
        step();
        bus.req0 = 1;
        #2;
        rst_n = 0;
        #1;
        check("t6_out_valid", 32'(bus.out_valid), 0);
        check("t6_out_data", 32'(bus.out_data), 0);
        check("t6_count", 32'(bus.count), 0);
        check("t6_err", 32'(bus.err), 0);
        check("t6_flush_done", 32'(bus.flush_done), 0);
        check("t6_gnt0", 32'(bus.gnt0), 0);
        check("t6_data_in_valid", 32'(bus.data_in_valid), 0);
        check("t6_pop", 32'(bus.pop_fifo), 0);
        fq.delete();
        fifo_drive();
        model_reset();
        bus.req0 = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t6_rst_flush_done", 32'(bus.flush_done), 0);
        end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_done", 32'(s_fd), 0);
        end
        bus.req0 = 1; bus.data0 = 16'hF00D; bus.out_ready = 1;
        step();
        check("t6_run_gnt0", 32'(s_gnt0), 1);
        bus.req0 = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
